// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Multi-cycle fetch / next-PC controller for the RISC-V datapath.
//            Owns the architectural PC, issues instruction-fetch requests,
//            waits for the datapath to finish each instruction and then
//            selects the next PC (PC+4, PC+imm, or (rs1+imm)&~1). Also keeps
//            a retired-instruction counter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   RESET_PC     PC loaded on reset
//   TRAP_PC      redirect target for a misaligned next PC (trap build only)
// Ports:
//   clock        in   1   system clock, rising edge
//   reset        in   1   synchronous active-high reset
//   imem_req     out  1   fetch request, high throughout FETCH
//   imem_addr    out  32  fetch address (== pc)
//   imem_ack     in   1   fetch accepted/returned, sampled in FETCH only
//   instr_valid  out  1   pulse on first EXEC cycle
//   exec_done    in   1   datapath finished, sampled in EXEC only
//   branch_taken in   1   select pc+immediate
//   jalr         in   1   select (rs1_value+immediate)&~1, wins over branch
//   immediate    in   32  immediate operand
//   rs1_value    in   32  rs1 operand for JALR
//   pc           out  32  current PC
//   pc_plus4     out  32  pc+4 (combinational) for link-register write
//   instret      out  32  retired-instruction count (wraps)
//   trap         out  1   misaligned-target pulse (first FETCH after retire)
//   bad_addr     out  32  last offending target address
// Build option:
//   MISALIGN_TRAP_EN  defined   -> misaligned targets redirect to TRAP_PC,
//                                  pulse trap and capture bad_addr
//                     undefined -> next PC bits [1:0] are cleared,
//                                  trap and bad_addr are tied to 0
// ============================================================================
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        branch_taken,
    input  logic        jalr,
    input  logic [31:0] immediate,
    input  logic [31:0] rs1_value,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instret,
    output logic        trap,
    output logic [31:0] bad_addr
);

    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_FETCH = 2'd1;
    localparam logic [1:0] C_EXEC  = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic        w_imem_req;
    logic        r_instr_valid;
    logic [31:0] r_pc;
    logic [31:0] r_instret;
    logic [31:0] w_target;
    logic        w_retire;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            C_IDLE:  w_state_next = C_FETCH;
            C_FETCH: if (imem_ack)  w_state_next = C_EXEC;
            C_EXEC:  if (exec_done) w_state_next = C_FETCH;
            default: w_state_next = C_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_imem_req = 1'b0;
        w_retire   = 1'b0;
        case (r_state)
            C_FETCH: w_imem_req = 1'b1;
            C_EXEC:  w_retire   = exec_done;
            default: begin
                w_imem_req = 1'b0;
                w_retire   = 1'b0;
            end
        endcase
    end

    // instr_valid is registered so it marks exactly the first EXEC cycle:
    // it is set only on the FETCH->EXEC transition.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_instr_valid <= 1'b0;
        end else begin
            r_instr_valid <= (r_state == C_FETCH) && imem_ack;
        end
    end

    // ------------------------------------------------------------------
    // Next-PC selection; jalr has priority over branch_taken.
    // All sums wrap modulo 2^32.
    // ------------------------------------------------------------------
    always_comb begin
        w_target = r_pc + 32'd4;
        if (jalr) begin
            w_target = (rs1_value + immediate) & 32'hFFFF_FFFE;
        end else if (branch_taken) begin
            w_target = r_pc + immediate;
        end
    end

    // Retired-instruction counter
    always_ff @(posedge clock) begin
        if (reset) begin
            r_instret <= 32'd0;
        end else if (w_retire) begin
            r_instret <= r_instret + 32'd1;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic        w_misaligned;
    logic        r_trap;
    logic [31:0] r_bad_addr;

    assign w_misaligned = (w_target[1:0] != 2'b00);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_trap     <= 1'b0;
            r_bad_addr <= 32'd0;
        end else begin
            // trap is a single-cycle pulse following the retiring edge
            r_trap <= w_retire && w_misaligned;
            if (w_retire) begin
                if (w_misaligned) begin
                    r_pc       <= TRAP_PC;
                    r_bad_addr <= w_target;
                end else begin
                    r_pc <= w_target;
                end
            end
        end
    end

    assign trap     = r_trap;
    assign bad_addr = r_bad_addr;
`else
    // Without the trap, the low two bits of any target are simply dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (w_retire) begin
            r_pc <= w_target & 32'hFFFF_FFFC;
        end
    end

    assign trap     = 1'b0;
    assign bad_addr = 32'd0;
`endif

    assign imem_req    = w_imem_req;
    assign imem_addr   = r_pc;
    assign instr_valid = r_instr_valid;
    assign pc          = r_pc;
    assign pc_plus4    = r_pc + 32'd4;
    assign instret     = r_instret;

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle fetch/next-PC controller for the RISC-V datapath. It owns the architectural PC register and issues instruction-fetch requests to instruction memory. It waits for the datapath to finish each instruction, then selects the next PC: sequential (PC+4), PC-relative branch/JAL (PC+imm) or register-indirect JALR ((rs1+imm)&~1). It sits between the instruction memory port and the PC adder/immediate path and keeps a retired-instruction counter.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_PC, 32'h0000_0100, redirect target for misaligned-target trap (used only with macro).
- clock  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request, held high while in FETCH.
- imem_addr  out  32  fetch address, equals pc.
- imem_ack  in  1  memory accepted/returned fetch; sampled only in FETCH.
- instr_valid  out  1  one-cycle pulse: fetched instruction now presented to datapath.
- exec_done  in  1  datapath finished current instruction; sampled only in EXEC.
- branch_taken  in  1  take PC-relative target (branch taken or JAL).
- jalr  in  1  take register-indirect target; priority over branch_taken.
- immediate  in  32  immediate from immediate generator.
- rs1_value  in  32  rs1 operand for JALR.
- pc  out  32  current PC.
- pc_plus4  out  32  pc+4, combinational, for link-register write.
- instret  out  32  retired-instruction count.
- trap  out  1  one-cycle misaligned-target trap pulse.
- bad_addr  out  32  last offending target address.

## Operation
- States: IDLE, FETCH, EXEC. Two-bit state register.
- IDLE: entered on reset; unconditionally moves to FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc. If imem_ack=1, go to EXEC; otherwise stay. No timeout.
- EXEC: instr_valid=1 only on the first cycle of EXEC. If exec_done=1, load the next PC, increment instret and go to FETCH.
- next PC selection, sampled in the exec_done cycle:
  - jalr=1: (rs1_value+immediate) & 32'hFFFF_FFFE.
  - else branch_taken=1: pc+immediate.
  - else: pc+4.
- Arithmetic: all sums are 32-bit and wrap modulo 2^32 (PC 32'hFFFF_FFFC + 4 gives 0). Carry is discarded.
- instret wraps from 32'hFFFF_FFFF to 0.
- imem_ack outside FETCH and exec_done outside EXEC are ignored and have no effect.
- branch_taken, jalr, immediate and rs1_value are don't-care except in the exec_done cycle.

## Timing
- Reset values: pc=RESET_PC, state=IDLE, imem_req=0, instr_valid=0, instret=0, trap=0, bad_addr=0.
- Reset overrides everything, including mid-FETCH (request dropped next cycle) and mid-EXEC (no retire, no PC update).
- First imem_req is asserted 2 cycles after the reset-deassert edge (IDLE, then FETCH).
- FETCH with same-cycle ack → EXEC next cycle. instr_valid is high in that cycle.
- exec_done may coincide with instr_valid. Minimum 2 cycles per instruction.
- pc and instret update on the edge ending the exec_done cycle. The new pc appears on imem_addr in the following FETCH cycle.
- pc_plus4 is combinational from pc. All other outputs are registered or decoded from state.

## Configuration
- MISALIGN_TRAP_EN defined:
  - If the selected next PC has bits [1:0] != 0, pc loads TRAP_PC instead.
  - trap pulses high for the one cycle after the exec_done edge (first FETCH cycle).
  - bad_addr captures the offending target. instret still increments.
- MISALIGN_TRAP_EN undefined:
  - Next PC bits [1:0] are forced to 0.
  - trap and bad_addr are tied to 0.

## Test plan
- Reset with RESET_PC=0, ack and done always high → imem_addr sequence 0,4,8,C; one instruction per 2 cycles; instret=4 after four exec_done.
- pc=0x40, branch_taken=1, immediate=0xFFFF_FFF0 → next imem_addr=0x30. With jalr=1 also high, rs1=0x1001, imm=4 → 0x1004 (jalr wins).
- imem_ack withheld 5 cycles in FETCH → imem_req and imem_addr stable for 5 cycles; instr_valid stays 0; EXEC entered the cycle after ack.
- pc=0xFFFF_FFFC, sequential retire → imem_addr=0x0000_0000. With instret preset to 0xFFFF_FFFF via 2^32 retires (or forced), → instret=0.
- Reset asserted in EXEC before exec_done → pc=RESET_PC, instret unchanged-to-0, no trap, IDLE next cycle.
- MISALIGN_TRAP_EN on, branch to pc+2 from 0x80 → trap=1 one cycle, bad_addr=0x82, imem_addr=0x100. Macro off → imem_addr=0x80.
